// File: rtl/fwd_pkg.sv
// fwd_pkg: shared state type, select encoding and width helper for the forwarding operand unit
package fwd_pkg;
  typedef enum logic {RUN, LDSTALL} state_e;
  localparam int SEL_REGFILE = 0;
  function automatic int sel_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction
endpackage

// File: rtl/fwd_operand_unit_if.sv
// fwd_operand_unit_if: decode-side inputs, forwarding sources and registered operand outputs
interface fwd_operand_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 16
);
  import fwd_pkg::*;
  localparam int SEL_W = sel_w(NUM_SRC);
  logic                        valid_i;
  logic                        stall_i;
  logic                        flush_i;
  logic [NUM_OPS*ADDR_W-1:0]   rs_addr_i;
  logic [NUM_OPS*DATA_W-1:0]   rs_data_i;
  logic [NUM_SRC-1:0]          src_regwrite_i;
  logic [NUM_SRC-1:0]          src_is_load_i;
  logic [NUM_SRC*ADDR_W-1:0]   src_rd_i;
  logic [NUM_SRC*DATA_W-1:0]   src_data_i;
  logic [NUM_OPS*DATA_W-1:0]   op_data_o;
  logic                        op_valid_o;
  logic [NUM_OPS*SEL_W-1:0]    fwd_sel_o;
  logic                        hazard_stall_o;
  logic [CNT_W-1:0]            hazard_cnt_o;
  modport master (
    output valid_i, stall_i, flush_i, rs_addr_i, rs_data_i,
           src_regwrite_i, src_is_load_i, src_rd_i, src_data_i,
    input  op_data_o, op_valid_o, fwd_sel_o, hazard_stall_o, hazard_cnt_o
  );
  modport slave (
    input  valid_i, stall_i, flush_i, rs_addr_i, rs_data_i,
           src_regwrite_i, src_is_load_i, src_rd_i, src_data_i,
    output op_data_o, op_valid_o, fwd_sel_o, hazard_stall_o, hazard_cnt_o
  );
endinterface

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: priority match of one operand against all sources; youngest match wins
module fwd_operand_sel import fwd_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = sel_w(NUM_SRC)
) (
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [DATA_W-1:0]         rs_data,
  input  logic [NUM_SRC-1:0]        src_regwrite,
  input  logic [NUM_SRC-1:0]        src_is_load,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      hazardous
);
  // scan oldest to youngest so the youngest match overwrites the rest
  always_comb begin
    sel       = SEL_W'(SEL_REGFILE);
    data      = rs_data;
    hazardous = 1'b0;
    for (int j = NUM_SRC - 1; j >= 0; j--)
      if (src_regwrite[j] && src_rd[j*ADDR_W +: ADDR_W] == rs_addr && rs_addr != '0) begin
        sel       = SEL_W'(j + 1);
        data      = src_data[j*DATA_W +: DATA_W];
        hazardous = src_is_load[j];
      end
  end
endmodule

// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit: forwarding operand resolution with load-use stall and registered ID/EX stage
module fwd_operand_unit import fwd_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  fwd_operand_unit_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_SRC);
  state_e                     state_q, state_d;
  logic [NUM_OPS*DATA_W-1:0]  op_data_q, op_data_d, data_c;
  logic [NUM_OPS*SEL_W-1:0]   fwd_sel_q, fwd_sel_d, sel_c;
  logic [NUM_OPS-1:0]         haz_c;
  logic                       op_valid_q, op_valid_d, hazard;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    fwd_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_sel (
      .rs_addr      (bus.rs_addr_i[k*ADDR_W +: ADDR_W]),
      .rs_data      (bus.rs_data_i[k*DATA_W +: DATA_W]),
      .src_regwrite (bus.src_regwrite_i),
      .src_is_load  (bus.src_is_load_i),
      .src_rd       (bus.src_rd_i),
      .src_data     (bus.src_data_i),
      .sel          (sel_c[k*SEL_W +: SEL_W]),
      .data         (data_c[k*DATA_W +: DATA_W]),
      .hazardous    (haz_c[k])
    );
  end
  assign hazard             = bus.valid_i && |haz_c;
  assign bus.hazard_stall_o = hazard && !bus.flush_i;
  always_comb begin
    state_d    = state_q;
    op_data_d  = op_data_q;
    fwd_sel_d  = fwd_sel_q;
    op_valid_d = op_valid_q;
    cnt_d      = cnt_q;
    if (bus.flush_i) begin
      op_valid_d = 1'b0;
      fwd_sel_d  = '0;
      state_d    = RUN;
    end else if (bus.stall_i) begin
      state_d = state_q;
    end else if (hazard) begin
      op_valid_d = 1'b0;
      state_d    = LDSTALL;
      cnt_d      = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end else if (bus.valid_i) begin
      op_data_d  = data_c;
      fwd_sel_d  = sel_c;
      op_valid_d = 1'b1;
      state_d    = RUN;
    end else begin
      op_valid_d = 1'b0;
      state_d    = RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      op_data_q  <= '0;
      fwd_sel_q  <= '0;
      op_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      fwd_sel_q  <= fwd_sel_d;
      op_valid_q <= op_valid_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.op_data_o    = op_data_q;
  assign bus.fwd_sel_o    = fwd_sel_q;
  assign bus.op_valid_o   = op_valid_q;
  assign bus.hazard_cnt_o = cnt_q;
endmodule

// File: tb/tb_fwd_operand_unit.sv
// tb_fwd_operand_unit: vector table, directed hazard sequences and random traffic against a reference model
module tb_fwd_operand_unit;
  localparam int DW = 32, AW = 5, NS = 2, NO = 2, CW = 4, SW = 2;
  localparam logic [31:0] R0 = 32'h1000_0001, R1 = 32'h2000_0002;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fwd_operand_unit_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .NUM_OPS(NO), .CNT_W(CW)) bus ();
  fwd_operand_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .NUM_OPS(NO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus.slave)
  );
  logic [AW-1:0] addr[NO], rd[NS];
  logic [DW-1:0] rdat[NO], sd[NS];
  bit            we[NS], ld[NS];
  logic [DW-1:0] m_data[NO];
  int            m_sel[NO];
  bit            m_valid;
  int            m_cnt;
  int            n_err = 0, n_chk = 0;
  typedef struct {
    logic [4:0]  a0, a1, rd0, rd1;
    logic [1:0]  we;
    logic [31:0] s0, s1, e0, e1;
    int          sel0, sel1;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic void ref_op(input int k, output logic [DW-1:0] d, output int s, output bit h);
    s = 0; d = rdat[k]; h = 0;
    for (int j = 0; j < NS; j++)
      if (s == 0 && we[j] && rd[j] == addr[k] && addr[k] != 0) begin
        s = j + 1; d = sd[j]; h = ld[j];
      end
  endfunction
  task automatic drive(input bit v, input bit s, input bit f);
    bus.valid_i = v; bus.stall_i = s; bus.flush_i = f;
    for (int k = 0; k < NO; k++) begin
      bus.rs_addr_i[k*AW +: AW] = addr[k];
      bus.rs_data_i[k*DW +: DW] = rdat[k];
    end
    for (int j = 0; j < NS; j++) begin
      bus.src_regwrite_i[j] = we[j];
      bus.src_is_load_i[j]  = ld[j];
      bus.src_rd_i[j*AW +: AW] = rd[j];
      bus.src_data_i[j*DW +: DW] = sd[j];
    end
  endtask
  task automatic rand_in(input int amax);
    for (int k = 0; k < NO; k++) begin
      addr[k] = AW'($urandom_range(0, amax)); rdat[k] = $urandom;
    end
    for (int j = 0; j < NS; j++) begin
      we[j] = 1'($urandom_range(0, 1)); ld[j] = ($urandom_range(0, 3) == 0);
      rd[j] = AW'($urandom_range(0, amax)); sd[j] = $urandom;
    end
  endtask
  task automatic chk_out();
    chk("op_valid", 64'(bus.op_valid_o), 64'(m_valid));
    chk("hazard_cnt", 64'(bus.hazard_cnt_o), 64'(m_cnt));
    for (int k = 0; k < NO; k++) begin
      chk($sformatf("op_data%0d", k), 64'(bus.op_data_o[k*DW +: DW]), 64'(m_data[k]));
      chk($sformatf("fwd_sel%0d", k), 64'(bus.fwd_sel_o[k*SW +: SW]), 64'(m_sel[k]));
    end
  endtask
  task automatic cycle(input bit v, input bit s, input bit f);
    logic [DW-1:0] d;
    int            sl;
    bit            h, haz;
    drive(v, s, f);
    haz = 0;
    for (int k = 0; k < NO; k++) begin
      ref_op(k, d, sl, h);
      haz |= h;
    end
    haz &= v;
    #1;
    chk("hazard_stall", 64'(bus.hazard_stall_o), 64'(haz && !f));
    @(posedge clk);
    if (f) begin
      m_valid = 0;
      for (int k = 0; k < NO; k++) m_sel[k] = 0;
    end else if (s) begin
    end else if (haz) begin
      m_valid = 0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (v) begin
      m_valid = 1;
      for (int k = 0; k < NO; k++) begin
        ref_op(k, d, sl, h);
        m_data[k] = d; m_sel[k] = sl;
      end
    end else m_valid = 0;
    #1;
    chk_out();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_in(3);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk);
    end
    #1;
    m_valid = 0; m_cnt = 0;
    for (int k = 0; k < NO; k++) begin m_data[k] = '0; m_sel[k] = 0; end
    chk_out();
    rst_n = 1'b1;
  endtask
  task automatic clear_src();
    for (int j = 0; j < NS; j++) begin we[j] = 0; ld[j] = 0; rd[j] = '0; sd[j] = '0; end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{5'd5, 5'd6, 5'd5, 5'd5, 2'b11, 32'hAAAA0000, 32'h11110000, 32'hAAAA0000, R1, 1, 0};
    tbl[1] = '{5'd5, 5'd6, 5'd5, 5'd5, 2'b10, 32'hAAAA0000, 32'h11110000, 32'h11110000, R1, 2, 0};
    tbl[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 32'h0000DEAD, 32'h0000BEEF, R0, R1, 0, 0};
    tbl[3] = '{5'd3, 5'd4, 5'd4, 5'd3, 2'b11, 32'h00000033, 32'h00000044, 32'h44, 32'h33, 2, 1};
    tbl[4] = '{5'd9, 5'd9, 5'd9, 5'd9, 2'b00, 32'h00000099, 32'h00000098, R0, R1, 0, 0};
    tbl[5] = '{5'd31, 5'd1, 5'd31, 5'd1, 2'b01, 32'h0000001F, 32'h00000001, 32'h1F, R1, 1, 0};
    do_reset();
    clear_src();
    addr[0] = 5'd1; addr[1] = 5'd2; rdat[0] = R0; rdat[1] = R1;
    cycle(1, 0, 0);
    chk("release_op0", 64'(bus.op_data_o[0 +: DW]), 64'(R0));
    chk("release_sel1", 64'(bus.fwd_sel_o[SW +: SW]), 64'd0);
    foreach (tbl[i]) begin
      addr[0] = tbl[i].a0; addr[1] = tbl[i].a1; rd[0] = tbl[i].rd0; rd[1] = tbl[i].rd1;
      we[0] = tbl[i].we[0]; we[1] = tbl[i].we[1]; ld[0] = 0; ld[1] = 0;
      sd[0] = tbl[i].s0; sd[1] = tbl[i].s1;
      cycle(1, 0, 0);
      chk($sformatf("tbl%0d_op0", i), 64'(bus.op_data_o[0 +: DW]), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_op1", i), 64'(bus.op_data_o[DW +: DW]), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_sel0", i), 64'(bus.fwd_sel_o[0 +: SW]), 64'(tbl[i].sel0));
      chk($sformatf("tbl%0d_sel1", i), 64'(bus.fwd_sel_o[SW +: SW]), 64'(tbl[i].sel1));
    end
    clear_src();
    addr[0] = 5'd7; addr[1] = 5'd0; we[0] = 1; ld[0] = 1; rd[0] = 5'd7; sd[0] = 32'h7777;
    cycle(1, 0, 0);
    chk("lu_bubble", 64'(bus.op_valid_o), 64'd0);
    chk("lu_cnt", 64'(bus.hazard_cnt_o), 64'd1);
    ld[0] = 0;
    cycle(1, 0, 0);
    chk("lu_capture", 64'(bus.op_data_o[0 +: DW]), 64'h7777);
    chk("lu_sel", 64'(bus.fwd_sel_o[0 +: SW]), 64'd1);
    chk("lu_valid", 64'(bus.op_valid_o), 64'd1);
    ld[0] = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0);
      chk("stall_cnt", 64'(bus.hazard_cnt_o), 64'd1);
      chk("stall_valid", 64'(bus.op_valid_o), 64'd1);
      chk("stall_data", 64'(bus.op_data_o[0 +: DW]), 64'h7777);
    end
    cycle(1, 0, 1);
    chk("flush_valid", 64'(bus.op_valid_o), 64'd0);
    chk("flush_sel", 64'(bus.fwd_sel_o[0 +: SW]), 64'd0);
    chk("flush_cnt", 64'(bus.hazard_cnt_o), 64'd1);
    do_reset();
    clear_src();
    addr[0] = 5'd7; addr[1] = 5'd3; we[0] = 1; ld[0] = 1; rd[0] = 5'd7;
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
    chk("sat_cnt", 64'(bus.hazard_cnt_o), 64'd15);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_in(3);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
